// File: rtl/mii_tx_arbiter.sv
// Shares one MII TX nibble path between NUM_REQ byte-stream requesters: round-robin
// per frame, preamble/SFD insertion, low-nibble-first serialisation and inter-frame gap.
module mii_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int IFG_NIBBLES = 24,
  parameter int MAX_BYTES   = 1522
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [3:0]           o_mii_txd,
  output logic                 o_mii_txen,
  output logic                 o_mii_txer,
  output logic                 o_busy,
  output logic                 o_abort_pulse
);
  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCW = ($clog2(MAX_BYTES + 1) > 11) ? $clog2(MAX_BYTES + 1) : 11;
  localparam int IGW = ($clog2(IFG_NIBBLES + 1) > 1) ? $clog2(IFG_NIBBLES + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_IFG  = 2'd3;

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PW-1:0]      r_gidx;
  logic [PW-1:0]      r_ptr;
  logic [3:0]         r_txd;
  logic               r_txen;
  logic               r_txer;
  logic               r_abort;
  logic               r_abt;      // abort cycle in progress (txer nibble on the wire)
  logic               r_phase;    // 1: low nibble on the wire, high nibble next
  logic               r_last;
  logic [3:0]         r_hi;
  logic [4:0]         r_nib_cnt;
  logic [BCW-1:0]     r_byte_cnt;
  logic [IGW-1:0]     r_ifg_cnt;

  logic               w_found;
  logic [PW-1:0]      w_win;
  logic [PW-1:0]      w_win_nxt;
  logic [PW:0]        w_sum;
  logic               w_fetch;
  logic               w_ready;
  logic               w_take;
  logic [7:0]         w_byte;

  // First valid requester searching upward from the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NUM_REQ)) w_sum = w_sum - (PW+1)'(NUM_REQ);
      if (!w_found && i_req_valid[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PW-1:0];
      end
    end
  end

  assign w_win_nxt = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // Fetch slots: the SFD cycle and every non-final high-nibble cycle.
  assign w_fetch = ((r_state == S_PRE) && (r_nib_cnt == 5'd16)) ||
                   ((r_state == S_DATA) && !r_abt && !r_phase && !r_last);
  assign w_ready = w_fetch && (r_byte_cnt < BCW'(MAX_BYTES));
  assign w_take  = w_ready && i_req_valid[r_gidx];
  assign w_byte  = i_req_data[{r_gidx, 3'b000} +: 8];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
    assign o_req_ready[g] = w_ready && (r_gidx == PW'(g));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_ptr      <= '0;
      r_txd      <= '0;
      r_txen     <= 1'b0;
      r_txer     <= 1'b0;
      r_abort    <= 1'b0;
      r_abt      <= 1'b0;
      r_phase    <= 1'b0;
      r_last     <= 1'b0;
      r_hi       <= '0;
      r_nib_cnt  <= '0;
      r_byte_cnt <= '0;
      r_ifg_cnt  <= '0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= '0;
            r_grant[w_win] <= 1'b1;
            r_gidx     <= w_win;
            r_ptr      <= w_win_nxt;
            r_state    <= S_PRE;
            r_txen     <= 1'b1;
            r_txd      <= 4'h5;
            r_nib_cnt  <= 5'd1;
            r_byte_cnt <= '0;
            r_last     <= 1'b0;
            r_phase    <= 1'b0;
          end
        end
        S_PRE: begin
          if (r_nib_cnt < 5'd16) begin
            r_nib_cnt <= r_nib_cnt + 5'd1;
            r_txd     <= (r_nib_cnt == 5'd15) ? 4'hD : 4'h5;
          end
        end
        S_DATA: begin
          if (r_abt || (!r_phase && r_last)) begin
            r_abt     <= 1'b0;
            r_txen    <= 1'b0;
            r_txer    <= 1'b0;
            r_txd     <= '0;
            r_grant   <= '0;
            r_state   <= S_IFG;
            r_ifg_cnt <= IGW'(1);
          end else if (r_phase) begin
            r_txd   <= r_hi;
            r_phase <= 1'b0;
          end
        end
        S_IFG: begin
          if (r_ifg_cnt == IGW'(IFG_NIBBLES)) r_state <= S_IDLE;
          else r_ifg_cnt <= r_ifg_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_fetch) begin
        r_state <= S_DATA;
        if (w_take) begin
          r_txd      <= w_byte[3:0];
          r_hi       <= w_byte[7:4];
          r_last     <= i_req_last[r_gidx];
          r_byte_cnt <= r_byte_cnt + 1'b1;
          r_phase    <= 1'b1;
        end else begin
          // Underrun or overlength: one txer nibble, then the gap.
          r_abt   <= 1'b1;
          r_txer  <= 1'b1;
          r_txd   <= '0;
          r_abort <= 1'b1;
        end
      end
    end
  end

  assign o_grant       = r_grant;
  assign o_mii_txd     = r_txd;
  assign o_mii_txen    = r_txen;
  assign o_mii_txer    = r_txer;
  assign o_busy        = (r_state != S_IDLE);
  assign o_abort_pulse = r_abort;
endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Bench for mii_tx_arbiter: queued byte sources, an MII frame monitor and a
// frame-level reference (preamble/SFD + nibbles, round-robin order, fixed gap).
module tb_mii_tx_arbiter;
  localparam int NREQ = 2;
  localparam int IFG  = 24;
  localparam int MAXB = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last  = '0;
  logic [8*NREQ-1:0] req_data  = '0;
  logic [NREQ-1:0]   req_ready, grant;
  logic [3:0]        txd;
  logic              txen, txer, busy, abort_pulse;
  int                checks = 0, errors = 0;

  always #5 clk = ~clk;

  mii_tx_arbiter #(.NUM_REQ(NREQ), .IFG_NIBBLES(IFG), .MAX_BYTES(MAXB)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_grant(grant),
    .o_mii_txd(txd), .o_mii_txen(txen), .o_mii_txer(txer), .o_busy(busy),
    .o_abort_pulse(abort_pulse));

  // Sources: each requester streams {last, byte} entries from its queue.
  logic [8:0] srcq[NREQ][$];
  int         popcnt[NREQ];
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (srcq[i].size() > 0) begin
        req_valid[i] = 1'b1; req_data[8*i +: 8] = srcq[i][0][7:0]; req_last[i] = srcq[i][0][8];
      end else begin
        req_valid[i] = 1'b0; req_data[8*i +: 8] = 8'h00; req_last[i] = 1'b0;
      end
      if (req_valid[i] && req_ready[i]) begin
        srcq[i].delete(0);
        popcnt[i]++;
      end
    end
  end

  // Monitor: collect every txen burst as a frame, then the busy-low gap after it.
  logic [3:0]      cap_nib[$];
  int              cap_len[$], cap_ifg[$];
  logic [NREQ-1:0] cap_grant[$];
  logic            cap_err[$];
  bit              in_frame = 0, in_ifg = 0, cur_err;
  int              cur_len, ifg_n, abort_cnt = 0, bad_prot = 0;
  logic [NREQ-1:0] cur_grant;
  initial forever begin
    @(negedge clk);
    if ((req_ready & ~grant) != '0) bad_prot++;
    if (txen != (grant != '0)) bad_prot++;
    if (abort_pulse) abort_cnt++;
    if (txen) begin
      if (!in_frame) begin in_frame = 1; cur_len = 0; cur_err = 0; cur_grant = grant; end
      cap_nib.push_back(txd); cur_len++;
      if (txer) cur_err = 1;
    end else begin
      if (in_frame) begin
        cap_len.push_back(cur_len); cap_err.push_back(cur_err); cap_grant.push_back(cur_grant);
        in_frame = 0; in_ifg = 1; ifg_n = 0;
      end
      if (in_ifg) begin
        if (busy) ifg_n++;
        else begin cap_ifg.push_back(ifg_n); in_ifg = 0; end
      end
    end
  end

  // Reference model state.
  logic [7:0]      mb[$];
  logic [3:0]      exp_nib[$];
  int              exp_len[$];
  logic [NREQ-1:0] exp_grant[$];
  logic            exp_err[$];
  int              pend_len[NREQ][$];
  logic [7:0]      pend_b[NREQ][$];
  int              nbad;

  task automatic clear_all();
    cap_nib.delete(); cap_len.delete(); cap_ifg.delete(); cap_grant.delete(); cap_err.delete();
    exp_nib.delete(); exp_len.delete(); exp_grant.delete(); exp_err.delete();
    in_frame = 0; in_ifg = 0; abort_cnt = 0;
    for (int i = 0; i < NREQ; i++) begin pend_len[i].delete(); pend_b[i].delete(); popcnt[i] = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) srcq[i].delete();
    repeat (2) @(negedge clk);
    clear_all();
    rst = 1'b0;
  endtask

  // Expected wire image of one frame: 15x5, D, bytes low nibble first, optional txer nibble.
  task automatic model_frame(input int req, input int nacc, input bit err);
    logic [NREQ-1:0] g;
    g = '0; g[req] = 1'b1;
    repeat (15) exp_nib.push_back(4'h5);
    exp_nib.push_back(4'hD);
    for (int i = 0; i < nacc; i++) begin exp_nib.push_back(mb[i][3:0]); exp_nib.push_back(mb[i][7:4]); end
    if (err) exp_nib.push_back(4'h0);
    exp_len.push_back(16 + 2*nacc + (err ? 1 : 0));
    exp_grant.push_back(g);
    exp_err.push_back(err);
  endtask

  task automatic push_frame(input int req, input int n, input bit with_last);
    for (int i = 0; i < n; i++) srcq[req].push_back({(with_last && i == n-1), mb[i]});
  endtask

  task automatic gen_frame(input int req, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      srcq[req].push_back({(i == n-1), b});
      pend_b[req].push_back(b);
    end
    pend_len[req].push_back(n);
  endtask

  // Round-robin over all queued frames, pointer starting at requester 0.
  task automatic model_rr();
    int p = 0, w, n;
    forever begin
      w = -1;
      for (int k = NREQ-1; k >= 0; k--) if (pend_len[(p+k)%NREQ].size() > 0) w = (p+k)%NREQ;
      if (w < 0) break;
      n = pend_len[w].pop_front();
      mb.delete();
      repeat (n) mb.push_back(pend_b[w].pop_front());
      model_frame(w, n, 1'b0);
      p = (w + 1) % NREQ;
    end
  endtask

  task automatic wait_frames(input int n, input string tag);
    int cyc = 0;
    while (cap_ifg.size() < n && cyc < 4000) begin @(negedge clk); cyc++; end
    checks++;
    if (cap_ifg.size() < n) begin
      errors++; $display("FAIL %s timeout: %0d frames seen, expected %0d", tag, cap_ifg.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 7;
    if (txen !== 1'b0)       begin errors++; $display("FAIL reset txen: got %b want 0", txen); end
    if (txd !== 4'h0)        begin errors++; $display("FAIL reset txd: got %h want 0", txd); end
    if (txer !== 1'b0)       begin errors++; $display("FAIL reset txer: got %b want 0", txer); end
    if (grant !== '0)        begin errors++; $display("FAIL reset grant: got %b want 00", grant); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (abort_pulse !== 1'b0) begin errors++; $display("FAIL reset abort: got %b want 0", abort_pulse); end
    if (req_ready !== '0)    begin errors++; $display("FAIL reset ready: got %b want 00", req_ready); end
    clear_all();
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    mb.delete();
    for (int i = 0; i < 64; i++) mb.push_back(8'(i));
    push_frame(0, 64, 1'b1);
    model_frame(0, 64, 1'b0);
    wait_frames(1, "single");
    checks++;
    if (cap_len.size() != 1 || cap_len[0] !== 144 || cap_grant[0] !== 2'b01 || cap_err[0] !== 1'b0 || cap_ifg[0] !== IFG) begin
      errors++; $display("FAIL single frame: len=%0d grant=%b err=%b ifg=%0d, want len=144 grant=01 err=0 ifg=%0d", cap_len[0], cap_grant[0], cap_err[0], cap_ifg[0], IFG);
    end
    nbad = 0;
    foreach (exp_nib[k]) if (k >= cap_nib.size() || cap_nib[k] !== exp_nib[k]) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL single nibbles: %0d wrong of %0d", nbad, exp_nib.size()); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int f = 0; f < 3; f++) begin gen_frame(0, 60); gen_frame(1, 60); end
    model_rr();
    wait_frames(6, "rr");
    checks++;
    if (cap_len.size() != 6) begin errors++; $display("FAIL rr nframes: got %0d want 6", cap_len.size()); end
    foreach (exp_len[f]) if (f < cap_len.size()) begin
      checks++;
      if (cap_grant[f] !== exp_grant[f] || cap_err[f] !== 1'b0 || cap_len[f] !== exp_len[f] || cap_ifg[f] !== IFG) begin
        errors++; $display("FAIL rr frame%0d: grant=%b err=%b len=%0d ifg=%0d, want grant=%b err=0 len=%0d ifg=%0d", f, cap_grant[f], cap_err[f], cap_len[f], cap_ifg[f], exp_grant[f], exp_len[f], IFG);
      end
    end
    nbad = 0;
    foreach (exp_nib[k]) if (k >= cap_nib.size() || cap_nib[k] !== exp_nib[k]) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL rr nibbles: %0d wrong of %0d", nbad, exp_nib.size()); end
  endtask

  task automatic test_underrun();
    int cyc = 0;
    do_reset();
    mb.delete();
    repeat (10) mb.push_back(8'($urandom));
    push_frame(1, 10, 1'b0);
    model_frame(1, 10, 1'b1);
    while (grant !== 2'b10 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (grant !== 2'b10) begin errors++; $display("FAIL underrun grant: got %b want 10", grant); end
    mb.delete();
    repeat (30) mb.push_back(8'($urandom));
    push_frame(0, 30, 1'b1);
    model_frame(0, 30, 1'b0);
    wait_frames(2, "underrun");
    checks++;
    if (abort_cnt != 1) begin errors++; $display("FAIL underrun abort_pulse cycles: got %0d want 1", abort_cnt); end
    foreach (exp_len[f]) begin
      checks++;
      if (cap_grant[f] !== exp_grant[f] || cap_err[f] !== exp_err[f] || cap_len[f] !== exp_len[f] || cap_ifg[f] !== IFG) begin
        errors++; $display("FAIL underrun frame%0d: grant=%b err=%b len=%0d ifg=%0d, want grant=%b err=%b len=%0d ifg=%0d", f, cap_grant[f], cap_err[f], cap_len[f], cap_ifg[f], exp_grant[f], exp_err[f], exp_len[f], IFG);
      end
    end
    nbad = 0;
    foreach (exp_nib[k]) if (k >= cap_nib.size() || cap_nib[k] !== exp_nib[k]) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL underrun nibbles: %0d wrong of %0d", nbad, exp_nib.size()); end
  endtask

  task automatic test_overlength();
    int cyc = 0;
    do_reset();
    mb.delete();
    repeat (70) mb.push_back(8'($urandom));
    push_frame(0, 70, 1'b0);
    model_frame(0, MAXB, 1'b1);
    while (abort_cnt == 0 && cyc < 400) begin @(negedge clk); cyc++; end
    srcq[0].delete();
    wait_frames(1, "overlen");
    checks += 3;
    if (popcnt[0] != MAXB) begin errors++; $display("FAIL overlen accepted: got %0d want %0d", popcnt[0], MAXB); end
    if (abort_cnt != 1) begin errors++; $display("FAIL overlen abort_pulse cycles: got %0d want 1", abort_cnt); end
    if (cap_grant[0] !== 2'b01 || cap_err[0] !== 1'b1 || cap_len[0] !== exp_len[0] || cap_ifg[0] !== IFG) begin
      errors++; $display("FAIL overlen frame: grant=%b err=%b len=%0d ifg=%0d, want grant=01 err=1 len=%0d ifg=%0d", cap_grant[0], cap_err[0], cap_len[0], cap_ifg[0], exp_len[0], IFG);
    end
    nbad = 0;
    foreach (exp_nib[k]) if (k >= cap_nib.size() || cap_nib[k] !== exp_nib[k]) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL overlen nibbles: %0d wrong of %0d", nbad, exp_nib.size()); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    do_reset();
    mb.delete();
    repeat (40) mb.push_back(8'($urandom));
    push_frame(0, 40, 1'b1);
    while (popcnt[0] < 20 && cyc < 400) begin @(negedge clk); cyc++; end
    checks++;
    if (popcnt[0] < 20) begin errors++; $display("FAIL rstmid progress: got %0d bytes want 20", popcnt[0]); end
    @(negedge clk);
    rst = 1'b1;
    srcq[0].delete();
    @(negedge clk);
    checks += 3;
    if (txen !== 1'b0) begin errors++; $display("FAIL rstmid txen: got %b want 0", txen); end
    if (grant !== '0)  begin errors++; $display("FAIL rstmid grant: got %b want 00", grant); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_all();
    gen_frame(1, 8);
    gen_frame(0, 8);
    model_rr();
    wait_frames(2, "rstmid");
    foreach (exp_len[f]) begin
      checks++;
      if (cap_grant[f] !== exp_grant[f] || cap_err[f] !== 1'b0 || cap_len[f] !== exp_len[f]) begin
        errors++; $display("FAIL rstmid frame%0d: grant=%b err=%b len=%0d, want grant=%b err=0 len=%0d", f, cap_grant[f], cap_err[f], cap_len[f], exp_grant[f], exp_len[f]);
      end
    end
  endtask

  task automatic test_min_frame();
    do_reset();
    mb.delete();
    mb.push_back(8'hA5);
    push_frame(0, 1, 1'b1);
    model_frame(0, 1, 1'b0);
    wait_frames(1, "min");
    checks++;
    if (cap_len[0] !== 18 || cap_err[0] !== 1'b0 || cap_ifg[0] !== IFG) begin
      errors++; $display("FAIL min frame: len=%0d err=%b ifg=%0d, want len=18 err=0 ifg=%0d", cap_len[0], cap_err[0], cap_ifg[0], IFG);
    end
    nbad = 0;
    foreach (exp_nib[k]) if (k >= cap_nib.size() || cap_nib[k] !== exp_nib[k]) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL min nibbles: %0d wrong of %0d", nbad, exp_nib.size()); end
  endtask

  task automatic test_random();
    int tot = 0;
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      int nf;
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin gen_frame(r, $urandom_range(1, MAXB)); tot++; end
    end
    model_rr();
    wait_frames(tot, "random");
    foreach (exp_len[f]) begin
      checks++;
      if (cap_grant[f] !== exp_grant[f] || cap_err[f] !== 1'b0 || cap_len[f] !== exp_len[f] || cap_ifg[f] !== IFG) begin
        errors++; $display("FAIL random frame%0d: grant=%b err=%b len=%0d ifg=%0d, want grant=%b err=0 len=%0d ifg=%0d", f, cap_grant[f], cap_err[f], cap_len[f], cap_ifg[f], exp_grant[f], exp_len[f], IFG);
      end
    end
    nbad = 0;
    foreach (exp_nib[k]) if (k >= cap_nib.size() || cap_nib[k] !== exp_nib[k]) nbad++;
    checks += 2;
    if (nbad != 0) begin errors++; $display("FAIL random nibbles: %0d wrong of %0d", nbad, exp_nib.size()); end
    if (bad_prot != 0) begin errors++; $display("FAIL ready/grant protocol: %0d bad cycles, want 0", bad_prot); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_underrun();
    test_overlength();
    test_reset_mid();
    test_min_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/mii_tx_arbiter.md
Name: mii_tx_arbiter

Overview:
- Shares the single MII transmit nibble path between NUM_REQ byte-stream requesters, for example an ARP responder and the IPv4 sender.
- Picks one requester per frame by round-robin and holds the grant for the whole frame.
- Generates preamble and SFD, serialises the requester's bytes low nibble first, then enforces the inter-frame gap.
- Requesters supply the full frame from DA through FCS. This block adds no padding and no FCS.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- IFG_NIBBLES, 24: idle nibble cycles after each frame (12 bytes).
- MAX_BYTES, 1522: maximum bytes per frame from DA through FCS.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of the frame.
- req_ready  out  NUM_REQ  byte accepted; asserted only to the granted requester.
- grant  out  NUM_REQ  one-hot owner of the current frame; zero when no frame is owned.
- mii_txd  out  4  transmit nibble.
- mii_txen  out  1  transmit enable.
- mii_txer  out  1  transmit error.
- busy  out  1  high in any state except IDLE.
- abort_pulse  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: state IDLE; grant=0; mii_txd=0; mii_txen=0; mii_txer=0; abort_pulse=0; round-robin pointer=0 (requester 0 has highest priority first).
- Reset during any state returns to IDLE on that edge; the partial frame is simply cut, with no txer.
- All MII outputs and grant are registered. req_ready is combinational from registered state.
- States: IDLE, PRE, DATA, IFG.
- IDLE:
  - If any req_valid is high, the winner is the first high bit searching upward from the pointer, wrapping around.
  - On the same edge: grant<=one-hot winner; pointer<=winner+1 (mod NUM_REQ); state<=PRE; mii_txen<=1; mii_txd<=4'h5; nibble counter<=1.
  - First preamble nibble appears one cycle after valid is seen.
- PRE:
  - Drives 15 nibbles of 4'h5, then one nibble of 4'hD (SFD), so 16 txen cycles in total.
  - The cycle in which mii_txd shows 4'hD is a fetch slot.
- Fetch slot rule:
  - Fetch slots are the SFD cycle and every DATA high-nibble cycle whose byte was not the last.
  - req_ready[g] is high only in a fetch slot and only while byte_count < MAX_BYTES.
  - If req_valid[g] is also high: the byte is accepted; mii_txd<=data[3:0]; data[7:4] and req_last are latched; byte_count+1; phase<=HI.
  - Next cycle: mii_txd<=latched high nibble.
- Last byte: after the high-nibble cycle of a byte flagged last, state<=IFG, mii_txen<=0, mii_txd<=0, grant<=0.
- Underrun: a fetch slot with req_valid[g] low aborts. The next cycle drives mii_txen=1, mii_txer=1, mii_txd=0 and abort_pulse=1 for exactly one cycle, then IFG. The requester must discard the rest of its frame; bytes it offers after the abort are not accepted for this frame.
- Overlength: a fetch slot with byte_count==MAX_BYTES is handled identically to underrun (ready stays low, abort).
- IFG:
  - Holds mii_txen=0 for IFG_NIBBLES cycles, counted from the first cycle txen is low, then returns to IDLE.
  - Requests are not sampled during IFG. Arbitration happens in the first IDLE cycle.
- Round-robin fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Simultaneous events:
  - req_last together with byte_count reaching MAX_BYTES on the same accepted byte is a legal frame, not an abort.
  - A requester asserting valid while not granted is ignored; its req_ready stays 0.
- Width rules: byte_count is 11 bits minimum and sized for MAX_BYTES; the nibble counter is 5 bits; the IFG counter is sized for IFG_NIBBLES.

Test Plan:
- Single frame: requester 0 sends 64 bytes 0x00..0x3F, last on 0x3F. Expect txen high for exactly 16+128 cycles; nibbles 5×15, D, then 0,0,1,0,2,0,…,F,3; then 24 low cycles before busy drops.
- Round-robin: both requesters hold valid for 3 frames each of 60 bytes. Expect grant sequence 01,10,01,10,01,10, with 24-cycle gaps between frames.
- Underrun: requester 1 drops valid at byte 10. Expect one cycle of txen=1, txer=1, txd=0; abort_pulse=1 for one cycle; then IFG; then the next frame is granted to requester 0 if it is pending.
- Overlength: MAX_BYTES=64, requester never asserts last. Expect 64 bytes accepted, req_ready low at the 65th fetch slot, txer pulse, abort_pulse.
- Reset mid-DATA: assert rst for 1 cycle at byte 20. Expect txen=0, grant=0, busy=0 on the next cycle, and pointer=0 (requester 0 wins a subsequent tie).
- Minimal frame: a 1-byte frame (last on first byte, 0xA5). Expect nibbles …D,5,A, then txen low.
